// File: rtl/color_decoder_if.sv
// Pixel stream and palette-write bundle for color_decoder.
// The master drives pixels and palette writes; the slave returns decoded RGB565 pixels.
interface color_decoder_if;
  logic [3:0]  Input;
  logic        InputValid;
  logic        Blank;
  logic        PalWrEn;
  logic [3:0]  PalWrAddr;
  logic [15:0] PalWrData;
  logic [15:0] Output;
  logic        OutputValid;

  modport master (
    output Input, InputValid, Blank, PalWrEn, PalWrAddr, PalWrData,
    input  Output, OutputValid
  );

  modport slave (
    input  Input, InputValid, Blank, PalWrEn, PalWrAddr, PalWrData,
    output Output, OutputValid
  );
endinterface

// File: rtl/color_decoder.sv
// 4-bit colour index to RGB565 decoder with one-cycle latency and a 16-entry palette.
// Define COLOR_DECODER_PALETTE_WR_EN for a writable palette; otherwise the palette is a fixed ROM.
module color_decoder #(
  parameter logic [15:0] BLANK_COLOR = 16'h0000
) (
  input logic            MasterCLK,
  input logic            Reset,
  color_decoder_if.slave bus
);

  function automatic logic [15:0] defaultEntry(input logic [3:0] idx);
    logic [15:0] val;
    case (idx)
      4'd0:    val = 16'h0000;
      4'd1:    val = 16'h0015;
      4'd2:    val = 16'h0540;
      4'd3:    val = 16'h0555;
      4'd4:    val = 16'hA800;
      4'd5:    val = 16'hA815;
      4'd6:    val = 16'hAAA0;
      4'd7:    val = 16'hAD55;
      4'd8:    val = 16'h52AA;
      4'd9:    val = 16'h52BF;
      4'd10:   val = 16'h57EA;
      4'd11:   val = 16'h57FF;
      4'd12:   val = 16'hFAAA;
      4'd13:   val = 16'hFABF;
      4'd14:   val = 16'hFFEA;
      default: val = 16'hFFFF;
    endcase
    return val;
  endfunction

  logic [15:0] rdData;

`ifdef COLOR_DECODER_PALETTE_WR_EN
  logic [15:0] palette [16];

  always_ff @(posedge MasterCLK or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < 16; i++) begin
        palette[i] <= defaultEntry(4'(i));
      end
    end else if (bus.PalWrEn) begin
      palette[bus.PalWrAddr] <= bus.PalWrData;
    end
  end

  // A write landing on the index being decoded is forwarded so the pixel sees the new colour.
  always_comb begin
    rdData = palette[bus.Input];
    if (bus.PalWrEn && (bus.PalWrAddr == bus.Input)) begin
      rdData = bus.PalWrData;
    end
  end
`else
  logic unusedWrPort;
  assign unusedWrPort = ^{bus.PalWrEn, bus.PalWrAddr, bus.PalWrData};

  always_comb begin
    rdData = defaultEntry(bus.Input);
  end
`endif

  always_ff @(posedge MasterCLK or posedge Reset) begin
    if (Reset) begin
      bus.Output      <= '0;
      bus.OutputValid <= 1'b0;
    end else begin
      bus.OutputValid <= bus.InputValid;
      if (bus.InputValid) begin
        bus.Output <= bus.Blank ? BLANK_COLOR : rdData;
      end
    end
  end

endmodule

// File: tb/tb_color_decoder.sv
// Self-checking bench for color_decoder: vector table driven through a scoreboard queue,
// plus hand-written palette-write and mid-stream reset sequences.
module tb_color_decoder;

  typedef struct {
    logic [3:0]  inp;
    logic        valid;
    logic        blank;
    logic        wrEn;
    logic [3:0]  wrAddr;
    logic [15:0] wrData;
    logic [15:0] expOut;
  } vec_t;

  logic MasterCLK = 1'b0;
  logic Reset     = 1'b1;

  color_decoder_if bus ();

  color_decoder #(.BLANK_COLOR(16'h0000)) dut (
    .MasterCLK (MasterCLK),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 MasterCLK = ~MasterCLK;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] sb [$];
  logic [15:0] lastOut = 16'h0000;
  vec_t        vecs [$];

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] inp, input logic valid, input logic blank,
                              input logic wrEn, input logic [3:0] wrAddr,
                              input logic [15:0] wrData, input logic [15:0] expOut);
    vec_t v;
    v.inp = inp; v.valid = valid; v.blank = blank;
    v.wrEn = wrEn; v.wrAddr = wrAddr; v.wrData = wrData; v.expOut = expOut;
    return v;
  endfunction

  task automatic applyVec(input vec_t v, input string name);
    logic [15:0] exp;
    bus.Input      = v.inp;
    bus.InputValid = v.valid;
    bus.Blank      = v.blank;
    bus.PalWrEn    = v.wrEn;
    bus.PalWrAddr  = v.wrAddr;
    bus.PalWrData  = v.wrData;
    if (v.valid) sb.push_back(v.expOut);
    @(posedge MasterCLK);
    #1;
    check({name, "_valid"}, 16'(bus.OutputValid), 16'(v.valid));
    if (bus.OutputValid === 1'b1) begin
      if (sb.size() == 0) begin
        check({name, "_sb_empty"}, bus.Output, 16'hxxxx);
      end else begin
        exp = sb.pop_front();
        check({name, "_pixel"}, bus.Output, exp);
        lastOut = exp;
      end
    end else begin
      check({name, "_hold"}, bus.Output, lastOut);
    end
  endtask

  task automatic idle();
    bus.InputValid = 1'b0;
    bus.PalWrEn    = 1'b0;
  endtask

  initial begin
    logic [15:0] defaults [16];
    defaults = '{16'h0000, 16'h0015, 16'h0540, 16'h0555, 16'hA800, 16'hA815, 16'hAAA0, 16'hAD55,
                 16'h52AA, 16'h52BF, 16'h57EA, 16'h57FF, 16'hFAAA, 16'hFABF, 16'hFFEA, 16'hFFFF};

    // Sweep 0..15 back to back, then blank, hold and wrap cases.
    for (int i = 0; i < 16; i++) vecs.push_back(mk(4'(i), 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, defaults[i]));
    vecs.push_back(mk(4'd4,  1'b1, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0000));
    vecs.push_back(mk(4'd12, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 16'hFAAA));
    vecs.push_back(mk(4'd5,  1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0000));
    vecs.push_back(mk(4'd9,  1'b0, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0000));
    vecs.push_back(mk(4'd15, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 16'hFFFF));
    vecs.push_back(mk(4'd0,  1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0000));
    vecs.push_back(mk(4'd7,  1'b1, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0000));
    vecs.push_back(mk(4'd11, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 16'h57FF));

    bus.Input = '0; bus.InputValid = 1'b0; bus.Blank = 1'b0;
    bus.PalWrEn = 1'b0; bus.PalWrAddr = '0; bus.PalWrData = '0;

    repeat (2) @(posedge MasterCLK);
    #1;
    check("reset_out", bus.Output, 16'h0000);
    check("reset_valid", 16'(bus.OutputValid), 16'h0);
    Reset = 1'b0;

    foreach (vecs[k]) applyVec(vecs[k], $sformatf("vec%0d", k));

    // Write and decode same index in one cycle, then unrelated and rewritten reads.
`ifdef COLOR_DECODER_PALETTE_WR_EN
    applyVec(mk(4'd3, 1'b1, 1'b0, 1'b1, 4'd3, 16'h1234, 16'h1234), "wr_bypass");
    applyVec(mk(4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0,    16'h0540), "rd_idx2");
    applyVec(mk(4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0,    16'h1234), "rd_idx3");
    applyVec(mk(4'd6, 1'b1, 1'b0, 1'b1, 4'd5, 16'hABCD, 16'hAAA0), "wr_other");
    applyVec(mk(4'd5, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0,    16'hABCD), "rd_idx5");
    applyVec(mk(4'd0, 1'b0, 1'b0, 1'b1, 4'd7, 16'hBEEF, 16'h0),    "wr_7");
    applyVec(mk(4'd7, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0,    16'hBEEF), "rd_idx7");
`else
    applyVec(mk(4'd3, 1'b1, 1'b0, 1'b1, 4'd3, 16'h1234, 16'h0555), "wr_bypass");
    applyVec(mk(4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0,    16'h0540), "rd_idx2");
    applyVec(mk(4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0,    16'h0555), "rd_idx3");
    applyVec(mk(4'd6, 1'b1, 1'b0, 1'b1, 4'd5, 16'hABCD, 16'hAAA0), "wr_other");
    applyVec(mk(4'd5, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0,    16'hA815), "rd_idx5");
    applyVec(mk(4'd0, 1'b0, 1'b0, 1'b1, 4'd7, 16'hBEEF, 16'h0),    "wr_7");
    applyVec(mk(4'd7, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0,    16'hAD55), "rd_idx7");
`endif

    // Reset arrives between edges with a valid pixel in flight.
    bus.Input = 4'd13; bus.InputValid = 1'b1; bus.Blank = 1'b0; bus.PalWrEn = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    check("midrst_out", bus.Output, 16'h0000);
    check("midrst_valid", 16'(bus.OutputValid), 16'h0);
    @(posedge MasterCLK);
    #1;
    check("rst_edge_out", bus.Output, 16'h0000);
    check("rst_edge_valid", 16'(bus.OutputValid), 16'h0);
    idle();
    #2;
    Reset = 1'b0;
    sb.delete();
    lastOut = 16'h0000;
    applyVec(mk(4'd7, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 16'hAD55), "post_rst_7");
    applyVec(mk(4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0555), "post_rst_3");
    applyVec(mk(4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0),    "post_rst_idle");

    check("sb_drained", 16'(sb.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
